// File: rtl/lsu_stage_if.sv
// Data-bus bundle between the load/store stage and the data memory.
// Single outstanding access: the master holds req/addr/we/wdata/wstrb
// until the slave returns a one-cycle ack with read data.
interface lsu_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store pipeline stage sitting between EX and WB.
// Non-memory ops flow through in one cycle. Aligned loads/stores launch
// a single bus access and freeze the front of the pipe until the ack.
// Misaligned accesses never reach the bus; they retire with a one-cycle
// misalign pulse and no register write.
module lsu_stage #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [BITWIDTH-1:0] ex_result,
    input  logic [BITWIDTH-1:0] ex_rs2Data,
    input  logic                ex_memRead,
    input  logic                ex_memWrite,
    input  logic [2:0]          ex_func3,
    input  logic [4:0]          ex_rd,
    input  logic                ex_regWrite,
    output logic                stall,
    lsu_stage_if.master         bus,
    output logic                mem_wb_valid,
    output logic [BITWIDTH-1:0] mem_wb_rdData,
    output logic [4:0]          mem_wb_rd,
    output logic                mem_wb_regWrite,
    output logic                misalign
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Access size after folding the reserved func3 codes onto word.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] decode_size(input logic [2:0] func3);
        logic [1:0] size;
        case (func3)
            3'b000, 3'b100: size = SZ_B;
            3'b001, 3'b101: size = SZ_H;
            default:        size = SZ_W;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (lo[0] == 1'b0);
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] data;
        case (size)
            SZ_B:    data = {4{rs2[7:0]}};
            SZ_H:    data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            SZ_B:    strb = 4'b0001 << lo;
            SZ_H:    strb = (lo == 2'b10 || lo == 2'b11) ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        zext,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] data;
        case (lo)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        case (lo)
            2'b00, 2'b01: lane_h = rdata[15:0];
            default:      lane_h = rdata[31:16];
        endcase
        case (size)
            SZ_B:    data = zext ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    data = zext ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
        return data;
    endfunction

    state_t        state_r;
    logic          bus_req_r;
    logic          bus_we_r;
    logic [31:0]   bus_addr_r;
    logic [31:0]   bus_wdata_r;
    logic [3:0]    bus_wstrb_r;
    logic          wb_valid_r;
    logic [31:0]   wb_data_r;
    logic [4:0]    wb_rd_r;
    logic          wb_rw_r;
    logic          misalign_r;
    logic [1:0]    lat_lo_r;
    logic [1:0]    lat_size_r;
    logic          lat_zext_r;
    logic [4:0]    lat_rd_r;
    logic          lat_rw_r;
    logic          lat_store_r;

    logic          mem_op_s;
    logic [1:0]    size_s;
    logic          aligned_s;
    logic          issue_s;
    logic          stall_s;

    // Decode the EX request and form the pipeline freeze.
    always_comb begin
        mem_op_s  = ex_memRead | ex_memWrite;
        size_s    = decode_size(ex_func3);
        aligned_s = is_aligned(size_s, ex_result[1:0]);
        issue_s   = (state_r == ST_IDLE) & ex_valid & mem_op_s & aligned_s;
        stall_s   = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else if (state_r == ST_BUSY) begin
            stall_s = ~bus.bus_ack;
        end else begin
            stall_s = issue_s;
        end
    end

    // Control FSM with registered bus and MEM/WB outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
            bus_wstrb_r <= 4'd0;
            wb_valid_r  <= 1'b0;
            wb_data_r   <= 32'd0;
            wb_rd_r     <= 5'd0;
            wb_rw_r     <= 1'b0;
            misalign_r  <= 1'b0;
            lat_lo_r    <= 2'd0;
            lat_size_r  <= 2'd0;
            lat_zext_r  <= 1'b0;
            lat_rd_r    <= 5'd0;
            lat_rw_r    <= 1'b0;
            lat_store_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    misalign_r <= 1'b0;
                    if (!ex_valid) begin
                        wb_valid_r <= 1'b0;
                        wb_data_r  <= 32'd0;
                        wb_rd_r    <= 5'd0;
                        wb_rw_r    <= 1'b0;
                    end else if (!mem_op_s) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= ex_result;
                        wb_rd_r    <= ex_rd;
                        wb_rw_r    <= ex_regWrite;
                    end else if (!aligned_s) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= 32'd0;
                        wb_rd_r    <= ex_rd;
                        wb_rw_r    <= 1'b0;
                        misalign_r <= 1'b1;
                    end else begin
                        // A write bit wins over a read bit: both set means store.
                        state_r     <= ST_BUSY;
                        wb_valid_r  <= 1'b0;
                        wb_rw_r     <= 1'b0;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= ex_memWrite;
                        bus_addr_r  <= {ex_result[31:2], 2'b00};
                        bus_wdata_r <= store_wdata(size_s, ex_rs2Data);
                        bus_wstrb_r <= ex_memWrite ? store_wstrb(size_s, ex_result[1:0]) : 4'b0000;
                        lat_lo_r    <= ex_result[1:0];
                        lat_size_r  <= size_s;
                        lat_zext_r  <= ex_func3[2];
                        lat_rd_r    <= ex_rd;
                        lat_rw_r    <= ex_regWrite;
                        lat_store_r <= ex_memWrite;
                    end
                end
                ST_BUSY: begin
                    misalign_r <= 1'b0;
                    if (bus.bus_ack) begin
                        state_r     <= ST_IDLE;
                        bus_req_r   <= 1'b0;
                        bus_we_r    <= 1'b0;
                        bus_wstrb_r <= 4'd0;
                        wb_valid_r  <= 1'b1;
                        wb_rd_r     <= lat_rd_r;
                        if (lat_store_r) begin
                            wb_data_r <= 32'd0;
                            wb_rw_r   <= 1'b0;
                        end else begin
                            wb_data_r <= load_extract(lat_size_r, lat_zext_r, lat_lo_r, bus.bus_rdata);
                            wb_rw_r   <= lat_rw_r;
                        end
                    end else begin
                        wb_valid_r <= 1'b0;
                        wb_rw_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    bus_req_r  <= 1'b0;
                    wb_valid_r <= 1'b0;
                    wb_rw_r    <= 1'b0;
                    misalign_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall           = stall_s;
    assign bus.bus_req     = bus_req_r;
    assign bus.bus_we      = bus_we_r;
    assign bus.bus_addr    = bus_addr_r;
    assign bus.bus_wdata   = bus_wdata_r;
    assign bus.bus_wstrb   = bus_wstrb_r;
    assign mem_wb_valid    = wb_valid_r;
    assign mem_wb_rdData   = wb_data_r;
    assign mem_wb_rd       = wb_rd_r;
    assign mem_wb_regWrite = wb_rw_r;
    assign misalign        = misalign_r;

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter: BITWIDTH, 32, datapath width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ex_valid  in  1  instruction present at the EX output this cycle.
REQ-006 ex_result  in  BITWIDTH  EX ALU result; this is the effective address for loads and stores.
REQ-007 ex_rs2Data  in  BITWIDTH  store data, already forwarded.
REQ-008 ex_memRead, ex_memWrite  in  1 each  load / store request.
REQ-009 ex_func3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 ex_rd  in  5, ex_regWrite  in  1  destination register and its write enable.
REQ-011 stall  out  1  freeze request to IF/ID/EX; combinational.
REQ-012 bus_req  out  1, bus_we  out  1  data-bus request and write enable.
REQ-013 bus_addr  out  32  word-aligned address (bits [1:0] = 00).
REQ-014 bus_wdata  out  32, bus_wstrb  out  4  write data and byte strobes.
REQ-015 bus_rdata  in  32, bus_ack  in  1  read data and single-cycle completion.
REQ-016 mem_wb_valid  out  1, mem_wb_rdData  out  BITWIDTH  registered MEM/WB valid and data.
REQ-017 mem_wb_rd  out  5, mem_wb_regWrite  out  1  registered destination and write enable.
REQ-018 misalign  out  1  registered one-cycle pulse on a misaligned access.

Function
REQ-019 The FSM SHALL have states IDLE and BUSY; each bus access is single-outstanding.
REQ-020 Non-memory op in IDLE: next cycle, mem_wb_* = {1, ex_result, ex_rd, ex_regWrite}; stall = 0.
REQ-021 Alignment: H requires addr[0] = 0; W requires addr[1:0] = 00; B is always aligned.
REQ-022 Aligned memory op in IDLE: stall = 1 that cycle; latch op, address, func3, rd and store data; go to BUSY.
REQ-023 BUSY: bus_req = 1 with stable bus_addr/we/wdata/wstrb until the cycle bus_ack = 1; stall = !bus_ack.
REQ-024 On the ack cycle: return to IDLE; next cycle mem_wb_valid = 1.
REQ-025 On that ack completion, mem_wb_regWrite = latched regWrite for loads and 0 for stores.
REQ-026 Load latency is 1 + N cycles from issue to mem_wb_valid, where N is ack wait cycles; minimum N = 1.
REQ-027 Load extract: byte lane = addr[1:0], halfword = addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-028 Store: B wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
REQ-029 Store: H wdata = {2{rs2[15:0]}}, wstrb = 0011 << {addr[1],0}.
REQ-030 Store: W wdata = rs2, wstrb = 1111.
REQ-031 Misaligned op: no bus request and stall = 0; next cycle misalign = 1, mem_wb_valid = 1, mem_wb_regWrite = 0.
REQ-032 memRead and memWrite both set: treated as a store.
REQ-033 Reserved func3 values (011, 110, 111): treated as W.
REQ-034 bus_ack in IDLE SHALL be ignored.
REQ-035 ex_valid = 0 in IDLE: next cycle mem_wb_valid = 0, regWrite = 0.
REQ-036 EX inputs SHALL be ignored while BUSY; they are held upstream by stall.

Reset
REQ-037 rst (any state, including BUSY mid-access) SHALL force, next edge: state IDLE, bus_req = 0, bus_we = 0, bus_wstrb = 0.
REQ-038 The same rst edge SHALL clear mem_wb_valid, mem_wb_regWrite and misalign, and zero mem_wb_rdData, mem_wb_rd and bus_addr.
REQ-039 stall SHALL read 0 during reset; an ack arriving after reset is ignored.

Verification
REQ-040 ALU pass: ex_result = 0x1234_5678, rd = 5, regWrite = 1 -> next cycle valid = 1, rdData = 0x1234_5678, rd = 5, stall = 0.
REQ-041 LB 0x103, rdata = 0x80FF_0000, ack after 2 wait cycles -> rdData = 0xFFFF_FF80; stall high 3 cycles. LBU same -> 0x0000_0080.
REQ-042 SH addr 0x202, rs2 = 0xABCD_1234 -> bus_addr = 0x200, wdata = 0x1234_1234, wstrb = 1100, we = 1; then mem_wb_regWrite = 0.
REQ-043 LW 0x101 -> no bus_req; next cycle misalign = 1, regWrite = 0.
REQ-044 LHU 0x106, rdata = 0xBEEF_0000 -> rdData = 0x0000_BEEF.
REQ-045 rst asserted in BUSY before ack -> bus_req = 0 and state IDLE next cycle; late ack causes no writeback.
